// File: rtl/sensor_ctrl_pkg.sv
// Shared types and constants for the theremin sensor drive sequencer.
// Imported by the NCO sub-block and the top-level controller.
package sensor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int LANES    = 8;
  localparam int MIN_HALF = 4;
  localparam int POPW     = $clog2(LANES + 1);

  function automatic logic [POPW-1:0] popcount(
    input logic [LANES-1:0] v
  );
    logic [POPW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + POPW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sensor_drive_nco.sv
// Square-wave phase generator: 8 serial lanes per parallel word,
// plus the half-period config holding register and apply logic.
module sensor_drive_nco
  import sensor_ctrl_pkg::*;
#(
  parameter int PW         = 12,
  parameter int RESET_HALF = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             idle,
  input  logic             cfg_valid,
  input  logic [PW-1:0]    cfg_half,
  output logic             cfg_ready,
  output logic [LANES-1:0] drive,
  output logic             wrap,
  output logic             apply
);

  localparam int CW = PW + 2;

  logic [PW-1:0]    half_q;
  logic [PW-1:0]    pend_q;
  logic             pend_v;
  logic [CW-1:0]    pos_q;
  logic [CW-1:0]    period;
  logic [CW-1:0]    pos_adv;
  logic [CW-1:0]    p;
  logic [LANES-1:0] lanes;

  // Below MIN_HALF a word could span two period wraps.
  function automatic logic [PW-1:0] clamp(
    input logic [PW-1:0] h
  );
    return (h < PW'(MIN_HALF)) ? PW'(MIN_HALF) : h;
  endfunction

  assign cfg_ready = !pend_v;
  assign period    = {1'b0, half_q, 1'b0};
  assign pos_adv   = pos_q + CW'(LANES);
  assign wrap      = run && (pos_adv >= period);
  assign apply     = pend_v && (idle || wrap);

  always_comb begin
    lanes = '0;
    p     = '0;
    for (int i = 0; i < LANES; i++) begin
      p = pos_q + CW'(i);
      if (p >= period) begin
        p = p - period;
      end
      lanes[i] = (p < {2'b00, half_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= PW'(RESET_HALF);
      pend_q <= '0;
      pend_v <= 1'b0;
      pos_q  <= '0;
      drive  <= '0;
    end else begin
      if (cfg_valid && !pend_v) begin
        pend_q <= cfg_half;
        pend_v <= 1'b1;
      end
      if (apply) begin
        half_q <= clamp(pend_q);
        pend_v <= 1'b0;
      end
      if (!run) begin
        pos_q <= '0;
        drive <= '0;
      end else begin
        drive <= lanes;
        if (apply) begin
          pos_q <= '0;
        end else if (wrap) begin
          pos_q <= pos_adv - period;
        end else begin
          pos_q <= pos_adv;
        end
      end
    end
  end

endmodule

// File: rtl/sensor_drive_ctrl.sv
// Sensor AFE sequencer: lock sync, IDLE/SETTLE/MEASURE control and
// windowed ref-vs-sense mismatch accumulation.
module sensor_drive_ctrl
  import sensor_ctrl_pkg::*;
#(
  parameter int PW            = 12,
  parameter int RW            = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 4096,
  parameter int RESET_HALF    = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PLL_LOCK,
  input  logic          ENABLE,
  input  logic          CFG_VALID,
  input  logic [PW-1:0] CFG_HALF,
  output logic          CFG_READY,
  input  logic [7:0]    REF_IN,
  input  logic [7:0]    SENSE_IN,
  output logic [7:0]    DRIVE_OUT,
  output logic [RW-1:0] RESULT,
  output logic          RESULT_VALID,
  output logic [1:0]    STATE
);

  localparam int SCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WCW =
    (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [1:0]       lock_ff;
  logic             sync_lock;
  logic             abort;
  state_t           state_q;
  state_t           state_d;
  logic [SCW-1:0]   settle_cnt;
  logic [WCW-1:0]   win_cnt;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    sum;
  logic [RW-1:0]    result_q;
  logic             valid_q;
  logic [LANES-1:0] ref_q;
  logic [LANES-1:0] sense_q;
  logic [POPW-1:0]  pop;
  logic             run;
  logic             idle;
  logic             nco_wrap;
  logic             nco_apply;
  logic             restart;
  logic             settle_done;
  logic             win_done;

  assign sync_lock = lock_ff[1];
  assign abort     = !sync_lock || !ENABLE;
  assign idle      = (state_q == IDLE);
  assign run       = !idle && !abort;
  // A config applied at a period wrap restarts the settle phase.
  assign restart   = nco_apply && nco_wrap;

  assign pop = popcount(ref_q ^ sense_q);
  assign sum = acc_q + RW'(pop);

  assign settle_done = (state_q == SETTLE) &&
    (settle_cnt == SCW'(SETTLE_CYCLES - 1));
  assign win_done = (state_q == MEASURE) &&
    (win_cnt == WCW'(WINDOW_CYCLES - 1));

  assign STATE        = state_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = valid_q;

  sensor_drive_nco #(
    .PW         (PW),
    .RESET_HALF (RESET_HALF)
  ) u_nco (
    .clk       (CLK),
    .rst       (RESET),
    .run       (run),
    .idle      (idle),
    .cfg_valid (CFG_VALID),
    .cfg_half  (CFG_HALF),
    .cfg_ready (CFG_READY),
    .drive     (DRIVE_OUT),
    .wrap      (nco_wrap),
    .apply     (nco_apply)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_ff <= '0;
    end else begin
      lock_ff <= {lock_ff[0], PLL_LOCK};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!abort) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = MEASURE;
      MEASURE: state_d = MEASURE;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = SETTLE;
    end
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ref_q      <= '0;
      sense_q    <= '0;
    end else begin
      ref_q   <= REF_IN;
      sense_q <= SENSE_IN;
      valid_q <= 1'b0;
      if (state_q == SETTLE && state_d == SETTLE && !restart) begin
        settle_cnt <= settle_cnt + SCW'(1);
      end else begin
        settle_cnt <= '0;
      end
      // Window end still reports if a config restart coincides.
      if (win_done && !abort) begin
        result_q <= sum;
        valid_q  <= 1'b1;
      end
      if (state_q == MEASURE && state_d == MEASURE && !win_done) begin
        acc_q   <= sum;
        win_cnt <= win_cnt + WCW'(1);
      end else begin
        acc_q   <= '0;
        win_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_drive_ctrl.sv
// Directed bench for sensor_drive_ctrl with a scoreboard of expected
// drive words and window results.
module tb_sensor_drive_ctrl;
  import sensor_ctrl_pkg::*;

  logic        clk;
  logic        RESET;
  logic        PLL_LOCK;
  logic        ENABLE;
  logic        CFG_VALID;
  logic [11:0] CFG_HALF;
  logic        CFG_READY;
  logic [7:0]  REF_IN;
  logic [7:0]  SENSE_IN;
  logic [7:0]  DRIVE_OUT;
  logic [15:0] RESULT;
  logic        RESULT_VALID;
  logic [1:0]  STATE;

  int checks = 0;
  int errors = 0;

  logic [7:0]  dq[$];
  logic [15:0] res_q[$];

  sensor_drive_ctrl #(
    .PW            (12),
    .RW            (16),
    .SETTLE_CYCLES (4),
    .WINDOW_CYCLES (16),
    .RESET_HALF    (64)
  ) dut (
    .CLK          (clk),
    .RESET        (RESET),
    .PLL_LOCK     (PLL_LOCK),
    .ENABLE       (ENABLE),
    .CFG_VALID    (CFG_VALID),
    .CFG_HALF     (CFG_HALF),
    .CFG_READY    (CFG_READY),
    .REF_IN       (REF_IN),
    .SENSE_IN     (SENSE_IN),
    .DRIVE_OUT    (DRIVE_OUT),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .STATE        (STATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial square wave: bit n of the stream is high for the first
  // half of each 2*half period.
  function automatic logic [7:0] exp_word(input int h, input int k);
    int he;
    logic [7:0] w;
    he = (h < 4) ? 4 : h;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[i] = (((8 * k + i) % (2 * he)) < he);
    end
    return w;
  endfunction

  task automatic wait_state(input logic [1:0] s, input int bound,
                            input string tag);
    int n;
    n = 0;
    while (STATE !== s && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(STATE), 32'(s));
  endtask

  task automatic send_cfg(input int h);
    int n;
    n = 0;
    CFG_HALF  = 12'(h);
    CFG_VALID = 1'b1;
    @(negedge clk);
    CFG_VALID = 1'b0;
    chk("cfg_accept", 32'(CFG_READY), 32'd0);
    while (!CFG_READY && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_idle_apply", 32'(CFG_READY), 32'd1);
  endtask

  task automatic run_pattern(input int h, input int nwords,
                             input string tag);
    ENABLE = 1'b0;
    repeat (2) @(negedge clk);
    send_cfg(h);
    for (int k = 0; k < nwords; k++) dq.push_back(exp_word(h, k));
    ENABLE = 1'b1;
    wait_state(SETTLE, 4, {tag, "_start"});
    chk({tag, "_first_zero"}, 32'(DRIVE_OUT), 32'd0);
    @(negedge clk);
    while (dq.size() > 0) begin
      chk(tag, 32'(DRIVE_OUT), 32'(dq.pop_front()));
      @(negedge clk);
    end
  endtask

  task automatic wait_rv(input int bound, output int n);
    n = 0;
    while (!RESULT_VALID && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int rv_seen;
    RESET     = 1'b1;
    PLL_LOCK  = 1'b0;
    ENABLE    = 1'b0;
    CFG_VALID = 1'b0;
    CFG_HALF  = '0;
    REF_IN    = '0;
    SENSE_IN  = '0;
    repeat (3) @(negedge clk);
    chk("rst_drive", 32'(DRIVE_OUT), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_valid", 32'(RESULT_VALID), 32'd0);
    chk("rst_ready", 32'(CFG_READY), 32'd1);
    chk("rst_state", 32'(STATE), 32'(IDLE));
    RESET = 1'b0;
    @(negedge clk);

    // Start-up: IDLE while lock syncs, exactly 4 SETTLE cycles.
    PLL_LOCK = 1'b1;
    ENABLE   = 1'b1;
    n = 0;
    while (STATE === IDLE && n < 6) begin
      chk("idle_drive_zero", 32'(DRIVE_OUT), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("start_settle", 32'(STATE), 32'(SETTLE));
    n = 0;
    while (STATE === SETTLE && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("settle_len", 32'(n), 32'd4);
    chk("start_measure", 32'(STATE), 32'(MEASURE));

    run_pattern(4, 6, "half4");
    run_pattern(8, 6, "half8");
    run_pattern(6, 6, "half6");
    run_pattern(2, 6, "half2_clamp");

    // Mismatch windows: all 8 lanes differ every cycle.
    ENABLE   = 1'b0;
    REF_IN   = 8'h00;
    SENSE_IN = 8'hFF;
    repeat (2) @(negedge clk);
    res_q.push_back(16'd128);
    res_q.push_back(16'd128);
    ENABLE = 1'b1;
    wait_state(MEASURE, 10, "res_enter");
    wait_rv(40, n);
    chk("res_first_latency", 32'(n), 32'd16);
    chk("res_w0", 32'(RESULT), 32'(res_q.pop_front()));
    @(negedge clk);
    chk("res_pulse_width", 32'(RESULT_VALID), 32'd0);
    wait_rv(40, n);
    chk("res_period", 32'(n + 1), 32'd16);
    chk("res_w1", 32'(RESULT), 32'(res_q.pop_front()));

    ENABLE = 1'b0;
    REF_IN = 8'h0F;
    repeat (2) @(negedge clk);
    res_q.push_back(16'd64);
    ENABLE = 1'b1;
    wait_state(MEASURE, 10, "res2_enter");
    wait_rv(40, n);
    chk("res2_seen", 32'(RESULT_VALID), 32'd1);
    chk("res2_w0", 32'(RESULT), 32'(res_q.pop_front()));

    // Lock loss mid-window.
    repeat (5) @(negedge clk);
    PLL_LOCK = 1'b0;
    n = 0;
    rv_seen = 0;
    while (STATE !== IDLE && n < 3) begin
      @(negedge clk);
      n++;
      if (RESULT_VALID) rv_seen = 1;
    end
    chk("lock_drop_idle", 32'(STATE), 32'(IDLE));
    chk("lock_drop_drive", 32'(DRIVE_OUT), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (RESULT_VALID) rv_seen = 1;
    end
    chk("lock_drop_no_rv", 32'(rv_seen), 32'd0);
    chk("lock_drop_hold", 32'(RESULT), 32'd64);
    chk("lock_drop_stay", 32'(STATE), 32'(IDLE));
    PLL_LOCK = 1'b1;

    // Config offered while measuring at half=8.
    ENABLE = 1'b0;
    repeat (2) @(negedge clk);
    send_cfg(8);
    ENABLE = 1'b1;
    wait_state(MEASURE, 14, "cfg_enter");
    CFG_HALF  = 12'd4;
    CFG_VALID = 1'b1;
    @(negedge clk);
    chk("cfg1_accept", 32'(CFG_READY), 32'd0);
    CFG_HALF = 12'd6;
    n = 0;
    while (!CFG_READY && n < 4) begin
      chk("cfg1_wait_state", 32'(STATE), 32'(MEASURE));
      @(negedge clk);
      n++;
    end
    chk("cfg1_wrap_wait", 32'((n >= 1) && (n <= 2)), 32'd1);
    chk("cfg1_settle", 32'(STATE), 32'(SETTLE));
    @(negedge clk);
    CFG_VALID = 1'b0;
    chk("cfg2_accept", 32'(CFG_READY), 32'd0);
    chk("cfg2_drive_h4", 32'(DRIVE_OUT), 32'h0F);
    @(negedge clk);
    chk("cfg2_apply", 32'(CFG_READY), 32'd1);
    chk("cfg2_settle", 32'(STATE), 32'(SETTLE));
    chk("cfg2_drive_last", 32'(DRIVE_OUT), 32'h0F);
    for (int k = 0; k < 4; k++) dq.push_back(exp_word(6, k));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cfg2_drive_h6", 32'(DRIVE_OUT), 32'(dq.pop_front()));
      chk("cfg2_resettle", 32'(STATE),
          (k < 3) ? 32'(SETTLE) : 32'(MEASURE));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
